// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the writeback sources
// (index 0 = ALU, 1 = LSU, 2 = MDU). A round-robin grant is issued
// combinationally in the same cycle as the request. The granted write is
// registered and driven onto the register file one cycle later.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  per-requester write request
//   req_addr_i   packed destination addresses, requester k at [k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]
//   req_data_i   packed write data, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o  one-hot grant; a transfer happens when valid and ready are both high
//   flush_i      blocks every grant in the current cycle
//   rf_we_o      registered write enable (never set for writes to x0)
//   rf_waddr_o   registered write address
//   rf_wdata_o   registered write data
//   grant_id_o   registered index of the requester that owns rf_*_o
//   wr_count_o   count of committed non-x0 writes, wraps at 2^32
module wb_port_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_W        = 32,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*RF_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         flush_i,
  output logic                         rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]     rf_waddr_o,
  output logic [DATA_W-1:0]            rf_wdata_o,
  output logic [ID_W-1:0]              grant_id_o,
  output logic [31:0]                  wr_count_o
);

  logic [ID_W-1:0]          rr_ptr_r;
  logic                     we_r;
  logic [RF_ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_W-1:0]        wdata_r;
  logic [ID_W-1:0]          grant_id_r;
  logic [31:0]              wr_count_r;

  logic [NUM_REQ-1:0]       grant_s;
  logic [ID_W-1:0]          grant_idx_s;
  logic [RF_ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_W-1:0]        sel_data_s;
  logic                     found_s;
  logic                     hs_s;
  logic [ID_W-1:0]          next_ptr_s;

  // Round-robin pick: scan offsets from rr_ptr and take the first valid index.
  // The inner loop over k keeps every bit select constant.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    grant_idx_s = {ID_W{1'b0}};
    sel_addr_s  = {RF_ADDR_WIDTH{1'b0}};
    sel_data_s  = {DATA_W{1'b0}};
    found_s     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found_s && req_valid_i[k] && (k == ((int'(rr_ptr_r) + i) % NUM_REQ))) begin
          grant_s[k]  = 1'b1;
          grant_idx_s = ID_W'(k);
          sel_addr_s  = req_addr_i[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
          sel_data_s  = req_data_i[k*DATA_W +: DATA_W];
          found_s     = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Flush and reset both mask the grant; a handshake only exists when a grant is visible.
  always_comb begin
    if (flush_i || rst_i) begin
      req_ready_o = {NUM_REQ{1'b0}};
      hs_s        = 1'b0;
    end else begin
      req_ready_o = grant_s;
      hs_s        = found_s;
    end
  end

  // Pointer moves one past the winner, wrapping at NUM_REQ-1.
  always_comb begin
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = {ID_W{1'b0}};
    end else begin
      next_ptr_s = grant_idx_s + ID_W'(1);
    end
  end

  // Output register, pointer and write counter; writes to x0 are consumed silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r   <= {ID_W{1'b0}};
      we_r       <= 1'b0;
      waddr_r    <= {RF_ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
      wr_count_r <= 32'd0;
    end else if (hs_s) begin
      rr_ptr_r   <= next_ptr_s;
      waddr_r    <= sel_addr_s;
      wdata_r    <= sel_data_s;
      grant_id_r <= grant_idx_s;
      we_r       <= (sel_addr_s != {RF_ADDR_WIDTH{1'b0}});
      if (sel_addr_s != {RF_ADDR_WIDTH{1'b0}}) begin
        wr_count_r <= wr_count_r + 32'd1;
      end
    end else begin
      we_r <= 1'b0;
    end
  end

  assign rf_we_o    = we_r;
  assign rf_waddr_o = waddr_r;
  assign rf_wdata_o = wdata_r;
  assign grant_id_o = grant_id_r;
  assign wr_count_o = wr_count_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  req_valid_i;
  logic [14:0] req_addr_i;
  logic [95:0] req_data_i;
  logic [2:0]  req_ready_o;
  logic        flush_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  grant_id_o;
  logic [31:0] wr_count_o;

  logic [4:0]  addr_v [3];
  logic [31:0] data_v [3];

  int checks_r;
  int errors_r;

  assign req_addr_i = {addr_v[2], addr_v[1], addr_v[0]};
  assign req_data_i = {data_v[2], data_v[1], data_v[0]};

  wb_port_arbiter #(
    .NUM_REQ(3),
    .RF_ADDR_WIDTH(5),
    .DATA_W(32)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .flush_i(flush_i),
    .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o),
    .grant_id_o(grant_id_o),
    .wr_count_o(wr_count_o)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expect a registered write from requester id on the outputs.
  task automatic expect_write(input string tag, input logic [1:0] id, input logic we,
                              input logic [4:0] a, input logic [31:0] d, input logic [31:0] cnt);
    check({tag, "_gid"}, 64'(grant_id_o), 64'(id));
    check({tag, "_we"}, 64'(rf_we_o), 64'(we));
    check({tag, "_waddr"}, 64'(rf_waddr_o), 64'(a));
    check({tag, "_wdata"}, 64'(rf_wdata_o), 64'(d));
    check({tag, "_cnt"}, 64'(wr_count_o), 64'(cnt));
  endtask

  initial begin
    logic [2:0] exp_rdy;
    logic [1:0] exp_id;
    checks_r    = 0;
    errors_r    = 0;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    req_valid_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 5'd0;
      data_v[i] = 32'd0;
    end

    // Reset state, with requests present while reset is held.
    #1;
    req_valid_i = 3'b111;
    #1;
    check("rst_ready", 64'(req_ready_o), 64'(3'b000));
    expect_write("rst", 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst_i = 1'b0;

    // Single write from requester 1.
    req_valid_i = 3'b010;
    addr_v[1]   = 5'd5;
    data_v[1]   = 32'hDEADBEEF;
    #1;
    check("single_ready", 64'(req_ready_o), 64'(3'b010));
    tick();
    expect_write("single", 2'd1, 1'b1, 5'd5, 32'hDEADBEEF, 32'd1);
    req_valid_i = 3'b000;
    tick();
    check("single_we_drop", 64'(rf_we_o), 64'(1'b0));
    check("single_cnt_hold", 64'(wr_count_o), 64'(32'd1));

    // Round-robin from a fresh reset with all three valid.
    rst_i = 1'b1;
    #1;
    check("rr_rst_cnt", 64'(wr_count_o), 64'(32'd0));
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 5'(i + 1);
      data_v[i] = 32'hA000_0000 + 32'(i);
    end
    req_valid_i = 3'b111;
    for (int j = 0; j < 6; j++) begin
      exp_id  = 2'(j % 3);
      exp_rdy = 3'b001 << exp_id;
      #1;
      check("rr_ready", 64'(req_ready_o), 64'(exp_rdy));
      tick();
      expect_write("rr", exp_id, 1'b1, 5'(exp_id) + 5'd1, 32'hA000_0000 + 32'(exp_id), 32'(j + 1));
    end

    // Reset asserted mid-stream right after a write was captured.
    tick();
    check("mid_we_before", 64'(rf_we_o), 64'(1'b1));
    check("mid_cnt_before", 64'(wr_count_o), 64'(32'd7));
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_ready", 64'(req_ready_o), 64'(3'b000));
    expect_write("mid_async", 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    check("mid_we_held", 64'(rf_we_o), 64'(1'b0));
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready_o), 64'(3'b001));
    tick();
    expect_write("post_rst", 2'd0, 1'b1, 5'd1, 32'hA000_0000, 32'd1);

    // Write to x0 from requester 0: consumed, not written, pointer advances to 1.
    req_valid_i = 3'b001;
    addr_v[0]   = 5'd0;
    data_v[0]   = 32'h0000_1234;
    #1;
    check("x0_ready", 64'(req_ready_o), 64'(3'b001));
    tick();
    expect_write("x0", 2'd0, 1'b0, 5'd0, 32'h0000_1234, 32'd1);

    // Flush blocks the grant; the pointer stays at 1.
    req_valid_i = 3'b011;
    addr_v[1]   = 5'd7;
    data_v[1]   = 32'hCAFE_0001;
    flush_i     = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready_o), 64'(3'b000));
    tick();
    check("flush_we", 64'(rf_we_o), 64'(1'b0));
    check("flush_cnt", 64'(wr_count_o), 64'(32'd1));
    flush_i = 1'b0;
    #1;
    check("after_flush_ready", 64'(req_ready_o), 64'(3'b010));
    tick();
    expect_write("after_flush", 2'd1, 1'b1, 5'd7, 32'hCAFE_0001, 32'd2);

    // Pointer wrap: 2 wins, then with only 0 and 2 valid, 0 then 2.
    addr_v[0]   = 5'd9;
    data_v[0]   = 32'h0BAD_F00D;
    req_valid_i = 3'b111;
    #1;
    check("wrap_ready2", 64'(req_ready_o), 64'(3'b100));
    tick();
    expect_write("wrap2", 2'd2, 1'b1, 5'd3, 32'hA000_0002, 32'd3);
    req_valid_i = 3'b101;
    #1;
    check("wrap_ready0", 64'(req_ready_o), 64'(3'b001));
    tick();
    expect_write("wrap0", 2'd0, 1'b1, 5'd9, 32'h0BAD_F00D, 32'd4);
    #1;
    check("wrap_ready2b", 64'(req_ready_o), 64'(3'b100));
    tick();
    expect_write("wrap2b", 2'd2, 1'b1, 5'd3, 32'hA000_0002, 32'd5);
    req_valid_i = 3'b000;
    tick();
    check("idle_we", 64'(rf_we_o), 64'(1'b0));
    check("idle_gid_hold", 64'(grant_id_o), 64'(2'd2));

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the writeback sources: ALU pipeline, load/store unit, and multiply/divide unit. Sits in front of the writeback stage's register-file interface. Each source has a valid/ready handshake. The block selects one source per cycle in round-robin order and drives a registered write onto the register file one cycle later. Writes to x0 are suppressed, and a flush input blocks new grants.

## Interface
Parameters:
- NUM_REQ, 3, number of write requesters (index 0 = ALU, 1 = LSU, 2 = MDU); must be ≥ 2
- RF_ADDR_WIDTH, 5, register-file address width
- DATA_W, 32, write data width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester write request
- req_addr_i  in  NUM_REQ*RF_ADDR_WIDTH  packed destination addresses; requester k at bits [k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]
- req_data_i  in  NUM_REQ*DATA_W  packed write data; requester k at bits [k*DATA_W +: DATA_W]
- req_ready_o  out  NUM_REQ  one-hot grant; handshake is valid&&ready in the same cycle
- flush_i  in  1  pipeline flush; suppresses all grants this cycle
- rf_we_o  out  1  register-file write enable, registered
- rf_waddr_o  out  RF_ADDR_WIDTH  register-file write address, registered
- rf_wdata_o  out  DATA_W  register-file write data, registered
- grant_id_o  out  $clog2(NUM_REQ)  index of the requester whose write is on rf_*_o, registered
- wr_count_o  out  32  count of committed non-x0 writes, wraps at 2^32

## Operation
State:
- rr_ptr: $clog2(NUM_REQ) bits, value in 0..NUM_REQ-1
- Output register: we, waddr, wdata, grant_id
- wr_count: 32-bit counter

Grant, combinational each cycle:
- If flush_i=1 or no req_valid_i bit is set, req_ready_o = 0.
- Otherwise, scan indices rr_ptr, rr_ptr+1, … modulo NUM_REQ. The first k with req_valid_i[k]=1 gets req_ready_o[k]=1. All other ready bits are 0.
- req_ready_o depends on req_valid_i. Requesters must not make req_valid_i depend on req_ready_o.

Requester rules:
- Hold valid, addr and data stable until the handshake completes.
- Valid may be dropped without a handshake only in a cycle where flush_i=1.

On a handshake with requester k at a rising edge:
- rr_ptr <= (k+1) mod NUM_REQ. With NUM_REQ=3, k=2 wraps to 0.
- waddr <= addr_k; wdata <= data_k; grant_id <= k.
- we <= (addr_k != 0). A write to x0 is accepted and consumed but never reaches the register file.
- wr_count <= wr_count + 1 only if addr_k != 0.

With no handshake:
- we <= 0. waddr, wdata and grant_id hold their values.
- rr_ptr and wr_count hold.

Reset (rst_i=1, any time):
- rr_ptr = 0; we = 0; waddr = 0; wdata = 0; grant_id = 0; wr_count = 0.
- req_ready_o = 0 while rst_i is high.
- A write captured but not yet driven is discarded. Asserting reset mid-stream produces no partial write.

Flush:
- Blocks grants in the same cycle, so rf_we_o is 0 in the following cycle.
- Does not cancel a write already on rf_*_o in the flush cycle; that write was committed before the flush.
- rr_ptr is unchanged by flush.

## Timing
- Grant latency: 0 cycles. req_ready_o is valid in the same cycle as req_valid_i.
- Write latency: 1 cycle. Handshake at edge t puts rf_we_o/rf_waddr_o/rf_wdata_o/grant_id_o on the outputs for cycle t+1, one cycle wide.
- wr_count_o updates at the same edge as rf_we_o.
- Throughput: one write per cycle, sustained.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles for a grant, excluding flush cycles.
- No combinational path from any input to rf_*_o, grant_id_o or wr_count_o.

## Test plan
- **Reset:** assert rst_i mid-stream, with a write just captured and all requests valid.
  - Outputs go to 0 asynchronously, before the next edge; the captured write never appears on rf_we_o.
  - After release, the first grant goes to requester 0.
- **Single write:** only req 1 valid, addr 5, data 0xDEADBEEF, at cycle t.
  - req_ready_o = 3'b010 at t.
  - At t+1: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, grant_id_o=1, wr_count_o=1.
  - At t+2: rf_we_o=0.
- **Round-robin:** all three requests valid continuously from reset.
  - Grants go 0,1,2,0,1,2, one per cycle.
  - rf_we_o stays high every cycle after the first.
  - wr_count_o increments every cycle.
- **x0 suppression:** req 0 valid, addr 0, data 0x1234.
  - req_ready_o[0]=1.
  - Next cycle: rf_we_o=0, grant_id_o=0, wr_count_o unchanged; rr_ptr advances to 1.
- **Flush:** reqs 0 and 1 valid with flush_i=1 for one cycle.
  - req_ready_o=0 that cycle; rf_we_o=0 the next cycle.
  - The following cycle grants the same index that would have won without the flush.
- **Pointer wrap:** req 2 granted, then only reqs 0 and 2 valid.
  - Req 0 wins next; then req 2.
